mem_stage_lsu: RTL and testbench

//  M-stage load/store unit of the 6-stage core. Issues data-bus transactions for loads/stores and

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 72 +++++++
 rtl/mem_stage_lsu.sv | 217 +++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and helpers for the M-stage load/store unit.
//               Holds the FSM state enum, the funct3 size codes and the
//               word-crossing predicate used by the LSU and its aligner.
// Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ1 = 2'd1,
      REQ2 = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // An access crosses into the next word when its last byte lands beyond
   // lane 3. Bytes never cross; halfwords cross only from offset 3.
   function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
      return ((size == SZ_H) && (off == 2'd3)) ||
             ((size == SZ_W) && (off != 2'd0));
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Purely combinational lane logic for the LSU.
//               Store side: byte-lane enables and lane-shifted write data for
//               the first word (lo) and, for word-crossing accesses, the
//               following word (hi).
//               Load side: merges two bus words little-endian, shifts the
//               addressed bytes down and sign/zero-extends to 32 bits.
// Ports       : st_size/st_off/st_data  store size, byte offset, raw data
//               be_lo/be_hi             lane enables, first/second word
//               wdata_lo/wdata_hi       shifted store data, first/second word
//               ld_size/ld_off/ld_zext  load size, byte offset, zero-extend
//               ld_lo/ld_hi             first/second bus read word
//               ld_data                 aligned, extended load result
// Revision    : 1.0  initial release
// ============================================================================
module lsu_align (
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  be_lo,
   output logic [3:0]  be_hi,
   output logic [31:0] wdata_lo,
   output logic [31:0] wdata_hi,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_zext,
   input  logic [31:0] ld_lo,
   input  logic [31:0] ld_hi,
   output logic [31:0] ld_data
);
   import lsu_pkg::*;

   logic [7:0]  size_mask;
   logic [7:0]  lanes;
   logic [63:0] st_wide;
   logic [31:0] ld_shifted;

   always_comb begin
      size_mask = 8'h0F;
      case (st_size)
         SZ_B:    size_mask = 8'h01;
         SZ_H:    size_mask = 8'h03;
         default: size_mask = 8'h0F;
      endcase
   end

   // Lanes and data are computed across an 8-byte window so that the part
   // spilling past lane 3 naturally lands in the second word.
   assign lanes    = size_mask << st_off;
   assign be_lo    = lanes[3:0];
   assign be_hi    = lanes[7:4];
   assign st_wide  = {32'd0, st_data} << {st_off, 3'b000};
   assign wdata_lo = st_wide[31:0];
   assign wdata_hi = st_wide[63:32];

   assign ld_shifted = 32'({ld_hi, ld_lo} >> {ld_off, 3'b000});

   always_comb begin
      ld_data = ld_shifted;
      case (ld_size)
         SZ_B: ld_data = ld_zext ? {24'd0, ld_shifted[7:0]}
                                 : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
         SZ_H: ld_data = ld_zext ? {16'd0, ld_shifted[15:0]}
                                 : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
         default: ld_data = ld_shifted;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : M-stage load/store unit. Issues registered data-bus
//               transactions, stalls IF..M while one is outstanding, and
//               returns an aligned, extended ReadDataM in the DONE cycle.
//               Word-crossing accesses are split into two bus transactions
//               when MISALIGNED_SPLIT_EN is defined; otherwise they are
//               rejected with a MisalignM pulse and no bus cycle.
// Params      : TIMEOUT_CYCLES  bus_ready wait limit per transaction (2..255)
// Ports       : clk, reset (async, active-high)
//               MemReadM/MemWriteM/ByteSrcM/ALUResultM/WriteDataM  request
//               bus_req/bus_we/bus_addr/bus_be/bus_wdata  registered bus out
//               bus_ready/bus_rdata                       bus response
//               ReadDataM/StallM/BusErrM/MisalignM        pipeline results
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage_lsu #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  ByteSrcM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        BusErrM,
   output logic        MisalignM
);
   import lsu_pkg::*;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_t  state;
   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic        zext_q;
   logic [7:0]  tcnt;

   logic        access;
   logic        cross_in;
   logic        timeout;
   logic [3:0]  be_lo;
   logic [3:0]  be_hi;
   logic [31:0] wdata_lo;
   logic [31:0] wdata_hi;
   logic [31:0] ld_lo;
   logic [31:0] load_data;

`ifdef MISALIGNED_SPLIT_EN
   logic        cross_q;
   logic [3:0]  be_hi_q;
   logic [31:0] wdata_hi_q;
   logic [31:0] rdata1_q;

   // In REQ2 the low bytes come from the word captured at the end of REQ1.
   assign ld_lo = (state == REQ2) ? rdata1_q : bus_rdata;
`else
   logic        unused_hi;

   assign ld_lo     = bus_rdata;
   assign unused_hi = ^{be_hi, wdata_hi};
`endif

   assign access   = MemReadM | MemWriteM;
   assign StallM   = access && (state != DONE);
   assign cross_in = crosses_word(ByteSrcM[1:0], ALUResultM[1:0]);
   // Ready in the last allowed cycle still completes the transaction.
   assign timeout  = !bus_ready && (tcnt == TO_LAST);

   lsu_align u_align (
      .st_size  (ByteSrcM[1:0]),
      .st_off   (ALUResultM[1:0]),
      .st_data  (WriteDataM),
      .be_lo    (be_lo),
      .be_hi    (be_hi),
      .wdata_lo (wdata_lo),
      .wdata_hi (wdata_hi),
      .ld_size  (size_q),
      .ld_off   (off_q),
      .ld_zext  (zext_q),
      .ld_lo    (ld_lo),
      .ld_hi    (bus_rdata),
      .ld_data  (load_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         size_q     <= 2'd0;
         off_q      <= 2'd0;
         zext_q     <= 1'b0;
         tcnt       <= 8'd0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= 32'd0;
         bus_be     <= 4'd0;
         bus_wdata  <= 32'd0;
         ReadDataM  <= 32'd0;
         BusErrM    <= 1'b0;
         MisalignM  <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
         cross_q    <= 1'b0;
         be_hi_q    <= 4'd0;
         wdata_hi_q <= 32'd0;
         rdata1_q   <= 32'd0;
`endif
      end else begin
         BusErrM   <= 1'b0;
         MisalignM <= 1'b0;
         case (state)
            IDLE: begin
               if (access) begin
                  size_q <= ByteSrcM[1:0];
                  off_q  <= ALUResultM[1:0];
                  zext_q <= ByteSrcM[2];
                  tcnt   <= 8'd0;
`ifndef MISALIGNED_SPLIT_EN
                  if (cross_in) begin
                     // Rejected without touching the bus; a store is dropped.
                     state     <= DONE;
                     MisalignM <= 1'b1;
                     ReadDataM <= 32'd0;
                  end else
`endif
                  begin
                     state     <= REQ1;
                     bus_req   <= 1'b1;
                     bus_we    <= MemWriteM;
                     bus_addr  <= {ALUResultM[31:2], 2'b00};
                     bus_be    <= be_lo;
                     bus_wdata <= wdata_lo;
`ifdef MISALIGNED_SPLIT_EN
                     cross_q    <= cross_in;
                     be_hi_q    <= be_hi;
                     wdata_hi_q <= wdata_hi;
`endif
                  end
               end
            end

            REQ1: begin
               if (bus_ready) begin
                  tcnt <= 8'd0;
`ifdef MISALIGNED_SPLIT_EN
                  if (cross_q) begin
                     state     <= REQ2;
                     rdata1_q  <= bus_rdata;
                     bus_addr  <= bus_addr + 32'd4;
                     bus_be    <= be_hi_q;
                     bus_wdata <= wdata_hi_q;
                  end else
`endif
                  begin
                     state     <= DONE;
                     bus_req   <= 1'b0;
                     bus_we    <= 1'b0;
                     ReadDataM <= bus_we ? 32'd0 : load_data;
                  end
               end else if (timeout) begin
                  state     <= DONE;
                  tcnt      <= 8'd0;
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  ReadDataM <= 32'd0;
                  BusErrM   <= 1'b1;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end

`ifdef MISALIGNED_SPLIT_EN
            REQ2: begin
               if (bus_ready) begin
                  state     <= DONE;
                  tcnt      <= 8'd0;
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  ReadDataM <= bus_we ? 32'd0 : load_data;
               end else if (timeout) begin
                  state     <= DONE;
                  tcnt      <= 8'd0;
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  ReadDataM <= 32'd0;
                  BusErrM   <= 1'b1;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end
`endif

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state   <= IDLE;
               bus_req <= 1'b0;
               bus_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu. A table of directed
//               load/store vectors with hand-computed bus and result values,
//               plus hand-written sequences for timeout, ready-at-timeout
//               and reset in the middle of a transaction.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage_lsu;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM;
   logic [2:0]  ByteSrcM;
   logic [31:0] ALUResultM, WriteDataM;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;
   logic [31:0] ReadDataM;
   logic        StallM, BusErrM, MisalignM;

   mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .ByteSrcM   (ByteSrcM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_be     (bus_be),
      .bus_wdata  (bus_wdata),
      .bus_ready  (bus_ready),
      .bus_rdata  (bus_rdata),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .BusErrM    (BusErrM),
      .MisalignM  (MisalignM)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] r1;
      logic [31:0] r2;
      int          n;
      logic [31:0] a1;
      logic [3:0]  be1;
      logic [31:0] wd1;
      logic [31:0] a2;
      logic [3:0]  be2;
      logic [31:0] wd2;
      logic [31:0] erd;
      bit          mis;
      int          stall;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;

   // Observations from the most recent access
   int          obs_n, obs_stall;
   bit          obs_done;
   logic [31:0] obs_addr [2];
   logic [3:0]  obs_be   [2];
   logic        obs_we   [2];
   logic [31:0] obs_wd   [2];
   logic [31:0] obs_rd;
   logic        obs_mis, obs_err;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit rd, bit wr, logic [2:0] f3, logic [31:0] addr,
                               logic [31:0] wd, logic [31:0] r1, logic [31:0] r2,
                               int n, logic [31:0] a1, logic [3:0] be1, logic [31:0] wd1,
                               logic [31:0] a2, logic [3:0] be2, logic [31:0] wd2,
                               logic [31:0] erd, bit mis, int stall);
      vec_t v;
      v.rd = rd;  v.wr = wr;  v.f3 = f3;  v.addr = addr; v.wd = wd;
      v.r1 = r1;  v.r2 = r2;  v.n = n;    v.a1 = a1;     v.be1 = be1;
      v.wd1 = wd1; v.a2 = a2; v.be2 = be2; v.wd2 = wd2;  v.erd = erd;
      v.mis = mis; v.stall = stall;
      return v;
   endfunction

   // Starts at posedge+1 in IDLE; acts as a zero-wait bus slave; returns
   // at posedge+1 of the IDLE cycle following DONE.
   task automatic access(input vec_t v);
      int cyc;
      obs_n = 0; obs_stall = 0; obs_done = 0;
      obs_rd = '0; obs_mis = 0; obs_err = 0;
      for (int k = 0; k < 2; k++) begin
         obs_addr[k] = '0; obs_be[k] = '0; obs_we[k] = 0; obs_wd[k] = '0;
      end
      MemReadM = v.rd; MemWriteM = v.wr; ByteSrcM = v.f3;
      ALUResultM = v.addr; WriteDataM = v.wd; bus_ready = 0;
      cyc = 0;
      while (!obs_done && cyc < 200) begin
         #1;
         if (StallM) obs_stall++;
         else begin
            obs_done = 1;
            obs_rd  = ReadDataM;
            obs_mis = MisalignM;
            obs_err = BusErrM;
         end
         if (bus_req && !obs_done) begin
            if (obs_n < 2) begin
               obs_addr[obs_n] = bus_addr; obs_be[obs_n] = bus_be;
               obs_we[obs_n]   = bus_we;   obs_wd[obs_n] = bus_wdata;
            end
            bus_rdata = (obs_n == 0) ? v.r1 : v.r2;
            bus_ready = 1;
            obs_n++;
         end else begin
            bus_ready = 0;
         end
         if (!obs_done) begin
            @(posedge clk); #1;
         end
         cyc++;
      end
      MemReadM = 0; MemWriteM = 0; bus_ready = 0;
      @(posedge clk); #1;
   endtask

   task automatic check_vec(input int i, input vec_t v);
      access(v);
      chk($sformatf("v%0d_done", i), 32'(obs_done), 32'd1);
      chk($sformatf("v%0d_nreq", i), obs_n, v.n);
      chk($sformatf("v%0d_stall", i), obs_stall, v.stall);
      chk($sformatf("v%0d_mis", i), 32'(obs_mis), 32'(v.mis));
      chk($sformatf("v%0d_err", i), 32'(obs_err), 32'd0);
      if (v.n >= 1) begin
         chk($sformatf("v%0d_addr1", i), obs_addr[0], v.a1);
         chk($sformatf("v%0d_be1", i), 32'(obs_be[0]), 32'(v.be1));
         chk($sformatf("v%0d_we1", i), 32'(obs_we[0]), 32'(v.wr));
         if (v.wr) chk($sformatf("v%0d_wdata1", i), obs_wd[0], v.wd1);
      end
      if (v.n == 2) begin
         chk($sformatf("v%0d_addr2", i), obs_addr[1], v.a2);
         chk($sformatf("v%0d_be2", i), 32'(obs_be[1]), 32'(v.be2));
         chk($sformatf("v%0d_we2", i), 32'(obs_we[1]), 32'(v.wr));
         if (v.wr) chk($sformatf("v%0d_wdata2", i), obs_wd[1], v.wd2);
      end
      if (v.rd) chk($sformatf("v%0d_rdata", i), obs_rd, v.erd);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt;
      bit done;

      //          rd wr f3      addr          wd            r1            r2            n  a1            be1    wd1           a2            be2    wd2           erd           mis stall
      vecs[0]  = mk(1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0,        1, 32'h0000_0100, 4'hF, 32'h0,        32'h0,        4'h0, 32'h0,        32'hDEAD_BEEF, 0, 2);
      vecs[1]  = mk(1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h8012_3456, 32'h0,        1, 32'h0000_0100, 4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF_FF80, 0, 2);
      vecs[2]  = mk(1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h8012_3456, 32'h0,        1, 32'h0000_0100, 4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000_0080, 0, 2);
      vecs[3]  = mk(0, 1, 3'b001, 32'h0000_0101, 32'h0000_ABCD, 32'h0,       32'h0,        1, 32'h0000_0100, 4'h6, 32'h00AB_CD00, 32'h0,        4'h0, 32'h0,        32'h0,        0, 2);
      vecs[4]  = mk(1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7777, 32'h0,        1, 32'h0000_0100, 4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF_8001, 0, 2);
      vecs[5]  = mk(1, 0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_7777, 32'h0,        1, 32'h0000_0100, 4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000_8001, 0, 2);
      vecs[6]  = mk(0, 1, 3'b000, 32'h0000_0202, 32'h1234_56A5, 32'h0,       32'h0,        1, 32'h0000_0200, 4'h4, 32'h56A5_0000, 32'h0,        4'h0, 32'h0,        32'h0,        0, 2);
      vecs[7]  = mk(0, 1, 3'b010, 32'h0000_030C, 32'hCAFE_F00D, 32'h0,       32'h0,        1, 32'h0000_030C, 4'hF, 32'hCAFE_F00D, 32'h0,        4'h0, 32'h0,        32'h0,        0, 2);
      vecs[8]  = mk(1, 0, 3'b000, 32'h0000_0101, 32'h0,        32'h1122_7F33, 32'h0,        1, 32'h0000_0100, 4'h2, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000_007F, 0, 2);
      vecs[9]  = mk(1, 0, 3'b001, 32'h0000_0100, 32'h0,        32'h1234_FFFE, 32'h0,        1, 32'h0000_0100, 4'h3, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF_FFFE, 0, 2);
      vecs[10] = mk(1, 0, 3'b000, 32'h0000_0106, 32'h0,        32'h00C3_0000, 32'h0,        1, 32'h0000_0104, 4'h4, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF_FFC3, 0, 2);
`ifdef MISALIGNED_SPLIT_EN
      vecs[11] = mk(1, 0, 3'b010, 32'h0000_0102, 32'h0,        32'h89AB_CDEF, 32'h0123_4567, 2, 32'h0000_0100, 4'hC, 32'h0,       32'h0000_0104, 4'h3, 32'h0,        32'h4567_89AB, 0, 3);
      vecs[12] = mk(0, 1, 3'b001, 32'h0000_0107, 32'h0000_BEEF, 32'h0,       32'h0,        2, 32'h0000_0104, 4'h8, 32'hEF00_0000, 32'h0000_0108, 4'h1, 32'h0000_00BE, 32'h0,        0, 3);
      vecs[13] = mk(1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h4433_2211, 32'h8877_6655, 2, 32'h0000_0100, 4'hE, 32'h0,       32'h0000_0104, 4'h1, 32'h0,        32'h5544_3322, 0, 3);
`else
      vecs[11] = mk(1, 0, 3'b010, 32'h0000_0102, 32'h0,        32'h89AB_CDEF, 32'h0123_4567, 0, 32'h0,       4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 1);
      vecs[12] = mk(0, 1, 3'b001, 32'h0000_0107, 32'h0000_BEEF, 32'h0,       32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 1);
      vecs[13] = mk(1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h4433_2211, 32'h8877_6655, 0, 32'h0,       4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 1);
`endif

      // Reset state
      reset = 1; MemReadM = 0; MemWriteM = 0; ByteSrcM = 3'b000;
      ALUResultM = '0; WriteDataM = '0; bus_ready = 0; bus_rdata = '0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_bus_req",   32'(bus_req),   32'd0);
      chk("rst_bus_we",    32'(bus_we),    32'd0);
      chk("rst_bus_addr",  bus_addr,       32'd0);
      chk("rst_bus_be",    32'(bus_be),    32'd0);
      chk("rst_bus_wdata", bus_wdata,      32'd0);
      chk("rst_readdata",  ReadDataM,      32'd0);
      chk("rst_buserr",    32'(BusErrM),   32'd0);
      chk("rst_misalign",  32'(MisalignM), 32'd0);
      chk("rst_stall",     32'(StallM),    32'd0);
      reset = 0;
      @(posedge clk); #1;

      // Directed table, issued back to back
      for (int i = 0; i < 14; i++) check_vec(i, vecs[i]);

      // Timeout: bus_ready never comes
      MemReadM = 1; ByteSrcM = 3'b010; ALUResultM = 32'h0000_0400; bus_ready = 0;
      cnt = 0; done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         #1;
         if (bus_req) cnt++;
         if (!StallM) begin
            done = 1;
            chk("to_buserr",   32'(BusErrM), 32'd1);
            chk("to_readdata", ReadDataM,    32'd0);
         end else begin
            @(posedge clk); #1;
         end
      end
      chk("to_done",       32'(done), 32'd1);
      chk("to_req_cycles", cnt,       TO);
      MemReadM = 0;
      @(posedge clk); #1;
      chk("to_err_pulse", 32'(BusErrM), 32'd0);

      // Ready arriving in the final allowed cycle wins over the timeout
      MemReadM = 1; ByteSrcM = 3'b010; ALUResultM = 32'h0000_0408; bus_ready = 0;
      bus_rdata = 32'h1357_9BDF;
      cnt = 0; done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         #1;
         if (!StallM) begin
            done = 1;
            chk("rw_buserr",   32'(BusErrM), 32'd0);
            chk("rw_readdata", ReadDataM,    32'h1357_9BDF);
         end else begin
            if (bus_req) begin
               cnt++;
               bus_ready = (cnt == TO);
            end
            @(posedge clk); #1;
         end
      end
      chk("rw_done",       32'(done), 32'd1);
      chk("rw_req_cycles", cnt,       TO);
      MemReadM = 0; bus_ready = 0;
      @(posedge clk); #1;

      // Reset while REQ1 waits for the bus
      MemReadM = 1; ByteSrcM = 3'b010; ALUResultM = 32'h0000_0500; bus_ready = 0;
      @(posedge clk); #1;
      chk("mr_req_before", 32'(bus_req), 32'd1);
      reset = 1;
      @(posedge clk); #1;
      chk("mr_bus_req",   32'(bus_req),   32'd0);
      chk("mr_bus_addr",  bus_addr,       32'd0);
      chk("mr_bus_be",    32'(bus_be),    32'd0);
      chk("mr_readdata",  ReadDataM,      32'd0);
      chk("mr_misalign",  32'(MisalignM), 32'd0);
      reset = 0; MemReadM = 0;
      @(posedge clk); #1;
      chk("mr_idle_req", 32'(bus_req), 32'd0);
      check_vec(100, vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
